// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared core-wide widths and the register-address / ROB-tag
//             types used by dispatch, the ROB and the register file.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;

   localparam int DEFAULT_XLEN  = 32;
   localparam int DEFAULT_NREG  = 32;
   localparam int DEFAULT_TAG_W = 4;
   localparam int DEFAULT_AW    = $clog2(DEFAULT_NREG);

   typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
   typedef logic [DEFAULT_TAG_W-1:0] rob_tag_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Brief    : One combinational read port. Takes the stored entry selected by
//             the address plus the commit bus, applies the commit bypass and
//             forces the hardwired-zero view of entry 0.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_port
   import core_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int TAG_W = DEFAULT_TAG_W,
   parameter int AW    = DEFAULT_AW
) (
   input  logic [AW-1:0]    addr,
   input  logic [XLEN-1:0]  st_data,
   input  logic             st_busy,
   input  logic [TAG_W-1:0] st_tag,
   input  logic             cm_en,
   input  logic [AW-1:0]    cm_rd,
   input  logic [TAG_W-1:0] cm_tag,
   input  logic [XLEN-1:0]  cm_data,
   output logic [XLEN-1:0]  data,
   output logic             busy,
   output logic [TAG_W-1:0] tag
);

   logic w_zero;
   logic w_hit;
   logic w_clear;

   assign w_zero  = (addr == '0);
   // A same-cycle commit to the addressed register is forwarded.
   assign w_hit   = cm_en && (cm_rd == addr) && !w_zero;
   // The commit only retires the rename if it is still the youngest producer.
   assign w_clear = w_hit && st_busy && (st_tag == cm_tag);

   // Bypass / zero-register selection; a same-cycle issue is never visible.
   always_comb begin
      data = st_data;
      busy = st_busy;
      tag  = st_tag;
      if (w_zero) begin
         data = '0;
         busy = 1'b0;
         tag  = '0;
      end else begin
         if (w_hit) begin
            data = cm_data;
         end
         if (w_clear) begin
            busy = 1'b0;
            tag  = '0;
         end
      end
   end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/tagged_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tagged_register_file
//  Brief    : Architectural register file with per-entry rename state
//             (busy bit + youngest producer ROB tag). Dispatch renames,
//             commit writes data and retires the rename on tag match,
//             flush drops all rename state.
//  Revision : 1.0  initial release
// ============================================================================
module tagged_register_file
   import core_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int NREG  = DEFAULT_NREG,
   parameter int TAG_W = DEFAULT_TAG_W,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic [NRD*TAG_W-1:0] rd_tag,
   input  logic               iss_en,
   input  logic [AW-1:0]      iss_rd,
   input  logic [TAG_W-1:0]   iss_tag,
   input  logic               cm_en,
   input  logic [AW-1:0]      cm_rd,
   input  logic [TAG_W-1:0]   cm_tag,
   input  logic [XLEN-1:0]    cm_data,
   input  logic               flush
);

   logic [XLEN-1:0]  r_data [NREG];
   logic             r_busy [NREG];
   logic [TAG_W-1:0] r_tag  [NREG];

   // Entry update: data follows every commit; busy/tag priority is
   // flush > issue > matching commit. Entry 0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            r_data[r] <= '0;
            r_busy[r] <= 1'b0;
            r_tag[r]  <= '0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (cm_en && (cm_rd == AW'(r))) begin
               r_data[r] <= cm_data;
            end
            if (flush) begin
               r_busy[r] <= 1'b0;
               r_tag[r]  <= '0;
            end else if (iss_en && (iss_rd == AW'(r))) begin
               r_busy[r] <= 1'b1;
               r_tag[r]  <= iss_tag;
            end else if (cm_en && (cm_rd == AW'(r)) && r_busy[r] &&
                         (r_tag[r] == cm_tag)) begin
               r_busy[r] <= 1'b0;
               r_tag[r]  <= '0;
            end
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr[i*AW +: AW];

      regfile_read_port #(
         .XLEN  (XLEN),
         .TAG_W (TAG_W),
         .AW    (AW)
      ) u_port (
         .addr    (w_addr),
         .st_data (r_data[w_addr]),
         .st_busy (r_busy[w_addr]),
         .st_tag  (r_tag[w_addr]),
         .cm_en   (cm_en),
         .cm_rd   (cm_rd),
         .cm_tag  (cm_tag),
         .cm_data (cm_data),
         .data    (rd_data[i*XLEN +: XLEN]),
         .busy    (rd_busy[i]),
         .tag     (rd_tag[i*TAG_W +: TAG_W])
      );
   end

endmodule : tagged_register_file
`default_nettype wire

// File: tb/tb_tagged_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tagged_register_file
//  Brief    : Directed self-checking bench. Expected read results are queued
//             as stimulus is applied and popped when the outputs are sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tagged_register_file;
   import core_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int TAG_W = 4;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic               clk;
   logic               rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NRD*TAG_W-1:0] rd_tag;
   logic               iss_en;
   reg_addr_t          iss_rd;
   rob_tag_t           iss_tag;
   logic               cm_en;
   reg_addr_t          cm_rd;
   rob_tag_t           cm_tag;
   logic [XLEN-1:0]    cm_data;
   logic               flush;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string            name;
      int               port;
      logic [XLEN-1:0]  data;
      logic             busy;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb[$];

   tagged_register_file #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W),
      .NRD   (NRD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_busy (rd_busy),
      .rd_tag  (rd_tag),
      .iss_en  (iss_en),
      .iss_rd  (iss_rd),
      .iss_tag (iss_tag),
      .cm_en   (cm_en),
      .cm_rd   (cm_rd),
      .cm_tag  (cm_tag),
      .cm_data (cm_data),
      .flush   (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Point a read port at a register and queue what it must return.
   task automatic expect_rd(input string name, input int port, input logic [AW-1:0] addr,
                            input logic [XLEN-1:0] d, input logic b, input logic [TAG_W-1:0] t);
      exp_t e;
      rd_addr[port*AW +: AW] = addr;
      e.name = name; e.port = port; e.data = d; e.busy = b; e.tag = t;
      sb.push_back(e);
   endtask

   // Let the combinational outputs settle, then drain the scoreboard.
   task automatic check_rd();
      exp_t e;
      logic [XLEN+TAG_W:0] obs;
      logic [XLEN+TAG_W:0] expv;
      #1;
      while (sb.size() > 0) begin
         e    = sb.pop_front();
         obs  = {rd_data[e.port*XLEN +: XLEN], rd_busy[e.port], rd_tag[e.port*TAG_W +: TAG_W]};
         expv = {e.data, e.busy, e.tag};
         checks++;
         assert (obs === expv) else begin
            errors++;
            $error("FAIL %s port %0d observed data=%h busy=%b tag=%h expected data=%h busy=%b tag=%h",
                   e.name, e.port, obs[XLEN+TAG_W:TAG_W+1], obs[TAG_W], obs[TAG_W-1:0],
                   e.data, e.busy, e.tag);
         end
      end
   endtask

   task automatic idle();
      iss_en = 1'b0; cm_en = 1'b0; flush = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] r, input logic [TAG_W-1:0] t);
      iss_en = 1'b1; iss_rd = r; iss_tag = t;
   endtask

   task automatic commit(input logic [AW-1:0] r, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
      cm_en = 1'b1; cm_rd = r; cm_tag = t; cm_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd_addr = '0;
      iss_en = 1'b0; iss_rd = '0; iss_tag = '0;
      cm_en = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0; flush = 1'b0;

      // Reset state on every register, both ports
      @(negedge clk); rst = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         expect_rd("reset_p0", 0, AW'(r), 32'h0, 1'b0, 4'h0);
         expect_rd("reset_p1", 1, AW'(r), 32'h0, 1'b0, 4'h0);
         check_rd();
      end

      // Rename x5 then commit with matching tag
      @(negedge clk); issue(5, 3);
      @(negedge clk); idle();
      expect_rd("x5_busy", 0, 5, 32'h0, 1'b1, 4'h3); check_rd();
      commit(5, 3, 32'hDEADBEEF);
      expect_rd("x5_bypass", 1, 5, 32'hDEADBEEF, 1'b0, 4'h0); check_rd();
      @(negedge clk); idle();
      expect_rd("x5_stored", 0, 5, 32'hDEADBEEF, 1'b0, 4'h0); check_rd();

      // Stale commit keeps the younger rename
      @(negedge clk); issue(7, 2);
      @(negedge clk); issue(7, 9);
      @(negedge clk); idle(); commit(7, 2, 32'h11);
      expect_rd("x7_stale_bypass", 0, 7, 32'h11, 1'b1, 4'h9); check_rd();
      @(negedge clk); idle();
      expect_rd("x7_stale_stored", 1, 7, 32'h11, 1'b1, 4'h9); check_rd();

      // Issue and matching commit to the same register in one cycle
      @(negedge clk); issue(4, 1);
      @(negedge clk); issue(4, 6); commit(4, 1, 32'h22);
      expect_rd("x4_same_cycle", 0, 4, 32'h22, 1'b0, 4'h0); check_rd();
      @(negedge clk); idle();
      expect_rd("x4_issue_wins", 1, 4, 32'h22, 1'b1, 4'h6); check_rd();

      // Flush drops rename state and a same-cycle issue, keeps commit data
      @(negedge clk); issue(1, 1);
      @(negedge clk); issue(2, 2);
      @(negedge clk); issue(3, 3);
      @(negedge clk); idle(); flush = 1'b1; issue(8, 4); commit(2, 5, 32'h33);
      expect_rd("x2_flush_bypass", 0, 2, 32'h33, 1'b1, 4'h2); check_rd();
      @(negedge clk); idle();
      expect_rd("x1_flushed", 0, 1, 32'h0, 1'b0, 4'h0);
      expect_rd("x2_flushed", 1, 2, 32'h33, 1'b0, 4'h0); check_rd();
      expect_rd("x3_flushed", 0, 3, 32'h0, 1'b0, 4'h0);
      expect_rd("x8_dropped", 1, 8, 32'h0, 1'b0, 4'h0); check_rd();
      expect_rd("x7_flushed", 0, 7, 32'h11, 1'b0, 4'h0);
      expect_rd("x4_flushed", 1, 4, 32'h22, 1'b0, 4'h0); check_rd();

      // Writes to x0 are ignored
      @(negedge clk); issue(0, 7); commit(0, 7, 32'hFFFFFFFF);
      expect_rd("x0_same_p0", 0, 0, 32'h0, 1'b0, 4'h0);
      expect_rd("x0_same_p1", 1, 0, 32'h0, 1'b0, 4'h0); check_rd();
      @(negedge clk); idle();
      expect_rd("x0_after_p0", 0, 0, 32'h0, 1'b0, 4'h0);
      expect_rd("x0_after_p1", 1, 0, 32'h0, 1'b0, 4'h0); check_rd();

      // Both ports on the same busy register
      @(negedge clk); issue(9, 10); commit(9, 1, 32'h99);
      @(negedge clk); idle();
      expect_rd("x9_p0", 0, 9, 32'h99, 1'b1, 4'hA);
      expect_rd("x9_p1", 1, 9, 32'h99, 1'b1, 4'hA); check_rd();

      // Asynchronous reset mid-run, checked before the next rising edge
      @(negedge clk); issue(3, 5);
      #2 rst = 1'b1;
      expect_rd("rst_x5", 0, 5, 32'h0, 1'b0, 4'h0);
      expect_rd("rst_x9", 1, 9, 32'h0, 1'b0, 4'h0); check_rd();
      @(negedge clk);
      expect_rd("rst_x3_held", 0, 3, 32'h0, 1'b0, 4'h0);
      expect_rd("rst_x7", 1, 7, 32'h0, 1'b0, 4'h0); check_rd();
      idle(); rst = 1'b0;
      @(negedge clk);
      expect_rd("post_rst_x3", 0, 3, 32'h0, 1'b0, 4'h0);
      expect_rd("post_rst_x4", 1, 4, 32'h0, 1'b0, 4'h0); check_rd();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_tagged_register_file
`default_nettype wire
